// File: rtl/mvu_pkg.sv
// Shared types and sizes for the MVU job sequencer.
package mvu_pkg;

  localparam int NMVU    = 6;
  localparam int BCNTDWN = 16;
  localparam int BMVUIDX = $clog2(NMVU);
  localparam int BJOBTAG = 8;

  typedef struct packed {
    logic [BMVUIDX-1:0] mvu;
    logic [BCNTDWN-1:0] countdown;
    logic [BJOBTAG-1:0] tag;
  } mvu_job_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CMPL
  } mvu_seq_state_t;

endpackage

// File: rtl/mvu_job_fifo.sv
// Synchronous job descriptor queue.
// ready_o is registered and always equals !full, so a push can never land on a
// full queue, even when the same cycle also pops.
module mvu_job_fifo
  import mvu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  mvu_job_t               din_i,
  output logic                   ready_o,
  input  logic                   pop_i,
  output mvu_job_t               dout_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  mvu_job_t        mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            ready_q, do_push, do_pop;

  assign do_push = push_i && ready_q;
  assign do_pop  = pop_i && (level_q != '0);
  assign level_d = level_q + LW'(do_push) - LW'(do_pop);

  // Pointers wrap naturally since DEPTH is a power of two; ready tracks next level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ready_q <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      level_q <= level_d;
      ready_q <= (level_d != LW'(DEPTH));
    end
  end

  // Storage array, no reset needed: only read behind valid occupancy.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q];
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/mvu_job_sequencer.sv
// MVU job sequencer: queues job descriptors, launches one job at a time on the
// target MVU, waits for its done, and reports completion with tag/err/irq.
// Optional watchdog: define MVU_SEQ_TIMEOUT_EN to end a hung job after
// job_countdown + TMARGIN cycles with cmpl_err=1.
module mvu_job_sequencer
  import mvu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TMARGIN    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        job_valid,
  output logic                        job_ready,
  input  logic [BMVUIDX-1:0]          job_mvu,
  input  logic [BCNTDWN-1:0]          job_countdown,
  input  logic [BJOBTAG-1:0]          job_tag,
  output logic [NMVU-1:0]             start,
  input  logic [NMVU-1:0]             done,
  output logic [NMVU-1:0]             irq,
  output logic                        cmpl_valid,
  output logic [BJOBTAG-1:0]          cmpl_tag,
  output logic                        cmpl_err,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam logic [BMVUIDX:0] NMVU_W = (BMVUIDX+1)'(NMVU);

  mvu_seq_state_t state_q, state_d;
  mvu_job_t       job_q, job_d, head, push_job;
  logic           err_q, err_d;
  logic           pop, empty, live, done_hit, bad_mvu, timeout;
  logic [NMVU-1:0] sel;

  assign push_job = '{mvu: job_mvu, countdown: job_countdown, tag: job_tag};

  mvu_job_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (job_valid),
    .din_i   (push_job),
    .ready_o (job_ready),
    .pop_i   (pop),
    .dout_o  (head),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  // One-hot decode of the current job's MVU; out-of-range indices decode to zero.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NMVU; i++) sel[i] = (job_q.mvu == BMVUIDX'(i));
  end

  assign bad_mvu  = ({1'b0, job_q.mvu} >= NMVU_W);
  assign done_hit = |(done & sel);

`ifdef MVU_SEQ_TIMEOUT_EN
  localparam int WDW = BCNTDWN + 1;
  logic [WDW-1:0] wd_q, wd_d, wd_lim;

  // wd_q holds cycles since the start pulse; the timeout decision is taken one
  // cycle early so cmpl_valid lands exactly countdown+TMARGIN after start.
  assign wd_lim  = {1'b0, job_q.countdown} + WDW'(TMARGIN);
  assign wd_d    = (state_q == S_LAUNCH) ? WDW'(1) : wd_q + WDW'(1);
  assign timeout = (wd_d >= wd_lim);

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  logic unused_cd;
  assign unused_cd = ^job_q.countdown;
  assign timeout   = 1'b0;
`endif

  // State, job and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      job_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; done is only looked at in WAIT, and done wins over timeout.
  always_comb begin
    state_d = state_q;
    job_d   = job_q;
    err_d   = err_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          job_d   = head;
          err_d   = 1'b0;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (bad_mvu) begin
          err_d   = 1'b1;
          state_d = S_CMPL;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done_hit) begin
          err_d   = 1'b0;
          state_d = S_CMPL;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_CMPL;
        end
      end
      S_CMPL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from state; held quiet while reset is asserted so an
  // abandoned job never reports.
  assign live       = !rst;
  assign start      = (live && state_q == S_LAUNCH) ? sel : '0;
  assign irq        = (live && state_q == S_CMPL) ? sel : '0;
  assign cmpl_valid = live && (state_q == S_CMPL);
  assign cmpl_tag   = cmpl_valid ? job_q.tag : '0;
  assign cmpl_err   = cmpl_valid && err_q;
  assign busy       = live && ((state_q != S_IDLE) || !empty);

endmodule

// File: tb/tb_mvu_job_sequencer.sv
module tb_mvu_job_sequencer;
  import mvu_pkg::*;

  localparam int FD = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               job_valid;
  logic               job_ready;
  logic [BMVUIDX-1:0] job_mvu;
  logic [BCNTDWN-1:0] job_countdown;
  logic [BJOBTAG-1:0] job_tag;
  logic [NMVU-1:0]    start, done, irq;
  logic               cmpl_valid, cmpl_err, busy;
  logic [BJOBTAG-1:0] cmpl_tag;
  logic [$clog2(FD):0] fifo_level;

  int tests = 0;
  int fails = 0;

  mvu_job_sequencer #(.FIFO_DEPTH(FD), .TMARGIN(16)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_mvu(job_mvu), .job_countdown(job_countdown), .job_tag(job_tag),
    .start(start), .done(done), .irq(irq), .cmpl_valid(cmpl_valid),
    .cmpl_tag(cmpl_tag), .cmpl_err(cmpl_err), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1; job_valid = 1'b0; done = '0;
    job_mvu = '0; job_countdown = '0; job_tag = '0;
    @(negedge clk); @(negedge clk);
    tests++; if (job_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", job_ready); end
    tests++; if (start !== 6'b0) begin fails++; $display("FAIL rst_start: got %b want 0", start); end
    tests++; if (irq !== 6'b0) begin fails++; $display("FAIL rst_irq: got %b want 0", irq); end
    tests++; if (cmpl_valid !== 1'b0) begin fails++; $display("FAIL rst_cmpl: got %b want 0", cmpl_valid); end
    tests++; if (cmpl_tag !== 8'h00 || cmpl_err !== 1'b0) begin fails++; $display("FAIL rst_tag_err: got %h/%b want 00/0", cmpl_tag, cmpl_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (job_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_after: got %b want 1", job_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_single();
    job_mvu = 3'd1; job_countdown = 16'd10; job_tag = 8'h5A; job_valid = 1'b1;
    @(negedge clk); job_valid = 1'b0;
    @(negedge clk);
    tests++; if (start !== 6'b000010) begin fails++; $display("FAIL single_start: got %b want 000010", start); end
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      tests++; if (start !== 6'b0) begin fails++; $display("FAIL single_start_extra n=%0d: got %b want 0", n, start); end
      tests++; if (cmpl_valid !== (n == 11)) begin fails++; $display("FAIL single_cmpl n=%0d: got %b want %b", n, cmpl_valid, (n == 11)); end
      if (n == 11) begin
        tests++; if (cmpl_tag !== 8'h5A) begin fails++; $display("FAIL single_tag: got %h want 5a", cmpl_tag); end
        tests++; if (cmpl_err !== 1'b0) begin fails++; $display("FAIL single_err: got %b want 0", cmpl_err); end
        tests++; if (irq !== 6'b000010) begin fails++; $display("FAIL single_irq: got %b want 000010", irq); end
      end else begin
        tests++; if (irq !== 6'b0) begin fails++; $display("FAIL single_irq_extra n=%0d: got %b want 0", n, irq); end
      end
      done = (n == 10) ? 6'b000010 : 6'b0;
    end
  endtask

  task automatic test_fifo_full();
    int exp_lvl [5] = '{1, 1, 2, 3, 4};
    int nxt = 0;
    int last_c = -1;
    int nstart = 0;
    bit pushed = 1'b0;
    bit dnow = 1'b0;
    job_mvu = 3'd0; job_countdown = 16'd3;
    for (int j = 0; j < 5; j++) begin
      job_tag = 8'h10 + 8'(j); job_valid = 1'b1;
      @(negedge clk);
      tests++; if (fifo_level !== 3'(exp_lvl[j])) begin fails++; $display("FAIL full_level j=%0d: got %0d want %0d", j, fifo_level, exp_lvl[j]); end
    end
    tests++; if (job_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b want 0", job_ready); end
    job_tag = 8'h15;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      tests++; if (job_ready !== 1'b0 || fifo_level !== 3'd4) begin fails++; $display("FAIL full_hold h=%0d: got ready=%b level=%0d want 0/4", h, job_ready, fifo_level); end
    end
    done = 6'b000001;
    for (int c = 0; c < 100 && nxt < 6; c++) begin
      @(negedge clk);
      done = '0;
      if (dnow) begin done = 6'b000001; dnow = 1'b0; end
      if (pushed) job_valid = 1'b0;
      pushed = job_valid && job_ready;
      if (start !== 6'b0) begin
        tests++; if (start !== 6'b000001) begin fails++; $display("FAIL full_start: got %b want 000001", start); end
        if (nstart > 0) begin
          tests++; if (c - last_c !== 4) begin fails++; $display("FAIL b2b_spacing: got %0d want 4", c - last_c); end
        end
        nstart++; last_c = c; dnow = 1'b1;
      end
      if (cmpl_valid) begin
        tests++; if (cmpl_tag !== 8'h10 + 8'(nxt)) begin fails++; $display("FAIL full_order: got %h want %h", cmpl_tag, 8'h10 + 8'(nxt)); end
        nxt++;
      end
    end
    job_valid = 1'b0;
    tests++; if (nxt !== 6) begin fails++; $display("FAIL full_all_done: got %0d want 6", nxt); end
    @(negedge clk);
    tests++; if (fifo_level !== 3'd0 || job_ready !== 1'b1) begin fails++; $display("FAIL full_drained: got level=%0d ready=%b want 0/1", fifo_level, job_ready); end
  endtask

  task automatic test_ignore_other();
    job_mvu = 3'd0; job_countdown = 16'd5; job_tag = 8'h37; job_valid = 1'b1;
    @(negedge clk); job_valid = 1'b0;
    @(negedge clk);
    tests++; if (start !== 6'b000001) begin fails++; $display("FAIL other_start: got %b want 000001", start); end
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      tests++; if (cmpl_valid !== (n == 8)) begin fails++; $display("FAIL other_cmpl n=%0d: got %b want %b", n, cmpl_valid, (n == 8)); end
      if (n == 8) begin
        tests++; if (cmpl_tag !== 8'h37 || cmpl_err !== 1'b0 || irq !== 6'b000001) begin
          fails++; $display("FAIL other_result: got tag=%h err=%b irq=%b want 37/0/000001", cmpl_tag, cmpl_err, irq);
        end
      end
      if (n == 2 || n == 3) done = 6'b000100;
      else if (n == 4)      done = 6'b111110;
      else if (n == 7)      done = 6'b000001;
      else                  done = 6'b0;
    end
  endtask

  task automatic test_invalid_mvu();
    for (int m = 6; m <= 7; m++) begin
      job_mvu = 3'(m); job_countdown = 16'd4; job_tag = 8'hE0 + 8'(m); job_valid = 1'b1;
      @(negedge clk); job_valid = 1'b0;
      for (int n = 2; n <= 5; n++) begin
        @(negedge clk);
        tests++; if (start !== 6'b0 || irq !== 6'b0) begin fails++; $display("FAIL bad_quiet m=%0d n=%0d: got start=%b irq=%b want 0/0", m, n, start, irq); end
        tests++; if (cmpl_valid !== (n == 3)) begin fails++; $display("FAIL bad_cmpl m=%0d n=%0d: got %b want %b", m, n, cmpl_valid, (n == 3)); end
        if (n == 3) begin
          tests++; if (cmpl_err !== 1'b1 || cmpl_tag !== 8'hE0 + 8'(m)) begin
            fails++; $display("FAIL bad_result m=%0d: got err=%b tag=%h want 1/%h", m, cmpl_err, cmpl_tag, 8'hE0 + 8'(m));
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    job_mvu = 3'd3; job_countdown = 16'd20; job_tag = 8'h70; job_valid = 1'b1;
    @(negedge clk); job_valid = 1'b0;
    @(negedge clk);
    tests++; if (start !== 6'b001000) begin fails++; $display("FAIL rmid_start: got %b want 001000", start); end
    job_tag = 8'h71; job_valid = 1'b1;
    @(negedge clk);
    job_tag = 8'h72;
    tests++; if (fifo_level !== 3'd1) begin fails++; $display("FAIL rmid_level1: got %0d want 1", fifo_level); end
    @(negedge clk);
    job_valid = 1'b0;
    tests++; if (fifo_level !== 3'd2) begin fails++; $display("FAIL rmid_level2: got %0d want 2", fifo_level); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++; if (cmpl_valid !== 1'b0 || irq !== 6'b0) begin fails++; $display("FAIL rmid_quiet_rst: got cmpl=%b irq=%b want 0/0", cmpl_valid, irq); end
    tests++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL rmid_flush: got %0d want 0", fifo_level); end
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      tests++; if (start !== 6'b0 || cmpl_valid !== 1'b0 || irq !== 6'b0) begin
        fails++; $display("FAIL rmid_abandon n=%0d: got start=%b cmpl=%b irq=%b want 0/0/0", n, start, cmpl_valid, irq);
      end
      tests++; if (busy !== 1'b0 || fifo_level !== 3'd0) begin fails++; $display("FAIL rmid_idle n=%0d: got busy=%b level=%0d want 0/0", n, busy, fifo_level); end
      done = (n % 2 == 0) ? 6'b001000 : 6'b0;
    end
    done = '0;
  endtask

`ifdef MVU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    for (int w = 0; w < 2; w++) begin
      job_mvu = 3'd4; job_countdown = 16'd8; job_tag = 8'hC4 + 8'(w); job_valid = 1'b1;
      @(negedge clk); job_valid = 1'b0;
      @(negedge clk);
      tests++; if (start !== 6'b010000) begin fails++; $display("FAIL wd_start w=%0d: got %b want 010000", w, start); end
      for (int n = 1; n <= 26; n++) begin
        @(negedge clk);
        tests++; if (cmpl_valid !== (n == 24)) begin fails++; $display("FAIL wd_cmpl w=%0d n=%0d: got %b want %b", w, n, cmpl_valid, (n == 24)); end
        if (n == 24) begin
          tests++; if (cmpl_err !== (w == 0) || cmpl_tag !== 8'hC4 + 8'(w) || irq !== 6'b010000) begin
            fails++; $display("FAIL wd_result w=%0d: got err=%b tag=%h irq=%b want %b/%h/010000", w, cmpl_err, cmpl_tag, irq, (w == 0), 8'hC4 + 8'(w));
          end
        end
        done = (w == 1 && n == 23) ? 6'b010000 : 6'b0;
      end
    end
  endtask
`else
  task automatic test_no_watchdog();
    job_mvu = 3'd5; job_countdown = 16'd1; job_tag = 8'hD5; job_valid = 1'b1;
    @(negedge clk); job_valid = 1'b0;
    @(negedge clk);
    tests++; if (start !== 6'b100000) begin fails++; $display("FAIL nowd_start: got %b want 100000", start); end
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      tests++; if (cmpl_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL nowd_wait n=%0d: got cmpl=%b busy=%b want 0/1", n, cmpl_valid, busy); end
    end
    done = 6'b100000;
    @(negedge clk);
    done = '0;
    tests++; if (cmpl_valid !== 1'b1 || cmpl_err !== 1'b0 || cmpl_tag !== 8'hD5) begin
      fails++; $display("FAIL nowd_result: got cmpl=%b err=%b tag=%h want 1/0/d5", cmpl_valid, cmpl_err, cmpl_tag);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fifo_full();
    test_ignore_other();
    test_invalid_mvu();
    test_reset_mid();
`ifdef MVU_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
